mult_hilo_sequencer: RTL and testbench

//  Multi-cycle sequencer for the HI/LO multiply path: mult, multu, madd, msub.

---
 rtl/mult_hilo_sequencer_if.sv | 27 ++
 rtl/mult_hilo_sequencer.sv | 108 ++++++++++
 tb/tb_mult_hilo_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_hilo_sequencer_if.sv
// Request/response bundle between decode and the HI/LO multiply sequencer.
// The master is the controller side; the slave is the sequencer.
interface mult_hilo_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             mf_req;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  modport master (
    output start, op, rs_val, rt_val, hi_we, lo_we, wdata, mf_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, hi_we, lo_we, wdata, mf_req,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/mult_hilo_sequencer.sv
// Shift-add HI/LO multiply sequencer (mult/multu/madd/msub) that also owns
// the HI/LO registers and raises stall on any HI/LO access while busy.
module mult_hilo_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  mult_hilo_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic               neg;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_rs, abs_rt;
  logic [2*WIDTH-1:0] p_fin, acc_val;

  // Signed ops run the unsigned core on magnitudes; the most negative value
  // negates to itself, which is exactly its unsigned magnitude.
  assign signed_op = (bus.op != 2'b01);
  assign abs_rs    = bus.rs_val[WIDTH-1] ? -bus.rs_val : bus.rs_val;
  assign abs_rt    = bus.rt_val[WIDTH-1] ? -bus.rt_val : bus.rt_val;
  assign p_fin     = neg ? -prod : prod;

  always_comb begin
    acc_val = p_fin;
    case (op_q)
      2'b10:   acc_val = {hi_q, lo_q} + p_fin;
      2'b11:   acc_val = {hi_q, lo_q} - p_fin;
      default: acc_val = p_fin;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (cnt == LAST) state_nxt = ACC;
      ACC:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q   <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // mthi/mtlo land on the same edge as a start; ACC reads them later.
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            op_q <= bus.op;
            prod <= '0;
            cnt  <= '0;
            if (signed_op) begin
              mcand  <= {{WIDTH{1'b0}}, abs_rs};
              mplier <= abs_rt;
              neg    <= bus.rs_val[WIDTH-1] ^ bus.rt_val[WIDTH-1];
            end else begin
              mcand  <= {{WIDTH{1'b0}}, bus.rs_val};
              mplier <= bus.rt_val;
              neg    <= 1'b0;
            end
          end
        end
        CALC: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        ACC:     {hi_q, lo_q} <= acc_val;
        default: ;
      endcase
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign bus.stall = bus.busy & (bus.start | bus.hi_we | bus.lo_we | bus.mf_req);
endmodule

// File: tb/tb_mult_hilo_sequencer.sv
// Directed and randomized checks of the HI/LO multiply sequencer against
// hand-computed values and a 64-bit multiply reference.
module tb_mult_hilo_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  mult_hilo_sequencer_if #(.WIDTH(32)) bus ();

  mult_hilo_sequencer #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch an op from IDLE; lat is the edge count from acceptance to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    bus.start = 1'b1; bus.op = o; bus.rs_val = a; bus.rt_val = b;
    tick();
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      tick();
      lat++;
    end
    if (!bus.done) chk("done_timeout", {63'b0, bus.done}, 64'd1);
  endtask

  task automatic finish_op();
    tick();
  endtask

  initial begin
    int          lat, n;
    bit          stall_ok, hi_ok, seen_done;
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] m, sp, up, p;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0; bus.mf_req = 1'b0;
    #12;
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_done", {62'b0, bus.busy, bus.done}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: mult 3*5 with exact latency and busy/stall observations
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    tick();
    bus.start = 1'b0;
    chk("t1_busy_after_accept", {63'b0, bus.busy}, 64'd1);
    bus.mf_req = 1'b1;
    #1;
    chk("t1_mf_stall_busy", {63'b0, bus.stall}, 64'd1);
    bus.mf_req = 1'b0;
    lat = 0;
    while (!bus.done && lat < 40) begin
      chk("t1_busy_calc", {63'b0, bus.busy}, 64'd1);
      tick();
      lat++;
    end
    chk("t1_latency", 64'(lat), 64'd33);
    chk("t1_result", {bus.hi, bus.lo}, 64'd15);
    tick();
    chk("t1_done_pulse", {62'b0, bus.busy, bus.done}, 64'd0);
    bus.mf_req = 1'b1;
    #1;
    chk("t1_mf_idle_nostall", {63'b0, bus.stall}, 64'd0);
    bus.mf_req = 1'b0;

    // 2: sign handling
    run_op(2'b00, 32'hFFFFFFFF, 32'd2, lat);
    chk("t2_mult_neg", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFE);
    finish_op();
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("t2_multu_max", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    finish_op();
    run_op(2'b00, 32'h80000000, 32'h80000000, lat);
    chk("t2_mult_minint", {bus.hi, bus.lo}, 64'h40000000_00000000);
    finish_op();

    // 3: mthi/mtlo then accumulate
    bus.hi_we = 1'b1; bus.wdata = 32'd0; tick(); bus.hi_we = 1'b0;
    bus.lo_we = 1'b1; bus.wdata = 32'd10; tick(); bus.lo_we = 1'b0;
    chk("t3_mtlo", {bus.hi, bus.lo}, 64'd10);
    run_op(2'b10, 32'd4, 32'd5, lat);
    chk("t3_madd", {bus.hi, bus.lo}, 64'd30);
    finish_op();
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'd0; tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    chk("t3_both_we", {bus.hi, bus.lo}, 64'd0);
    run_op(2'b11, 32'd1, 32'd1, lat);
    chk("t3_msub", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFFF);
    finish_op();
    bus.hi_we = 1'b1; bus.wdata = 32'd0; tick(); bus.hi_we = 1'b0;
    bus.lo_we = 1'b1; bus.wdata = 32'd100;
    run_op(2'b10, 32'd2, 32'hFFFFFFFD, lat);
    bus.lo_we = 1'b0;
    chk("t3_madd_same_edge_we", {bus.hi, bus.lo}, 64'd94);
    finish_op();

    // 4: start and hi_we held while busy
    bus.hi_we = 1'b1; bus.wdata = 32'd0; tick(); bus.hi_we = 1'b0;
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
    bus.hi_we = 1'b1; bus.wdata = 32'h0000AAAA;
    stall_ok = 1'b1; hi_ok = 1'b1; n = 0;
    while (!bus.done && n < 40) begin
      #1;
      if (!bus.stall) stall_ok = 1'b0;
      if (bus.hi !== 32'd0) hi_ok = 1'b0;
      tick();
      n++;
    end
    chk("t4_stall_held", {63'b0, stall_ok}, 64'd1);
    chk("t4_hi_unchanged", {63'b0, hi_ok}, 64'd1);
    chk("t4_first_result", {bus.hi, bus.lo}, 64'd6);
    chk("t4_stall_in_done", {63'b0, bus.stall}, 64'd1);
    tick();
    chk("t4_idle_nostall", {62'b0, bus.busy, bus.stall}, 64'd0);
    tick();
    bus.start = 1'b0; bus.hi_we = 1'b0;
    chk("t4_accept_and_write", {31'b0, bus.busy, bus.hi}, {31'b0, 1'b1, 32'h0000AAAA});
    n = 0;
    while (!bus.done && n < 40) begin
      tick();
      n++;
    end
    chk("t4_second_result", {bus.hi, bus.lo}, 64'd25);
    finish_op();

    // 5: reset mid-operation
    bus.start = 1'b1; bus.op = 2'b00; bus.rs_val = 32'd7; bus.rt_val = 32'd9;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("t5_reset_abort", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    #2;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) seen_done = 1'b1;
    end
    chk("t5_no_done", {63'b0, seen_done}, 64'd0);
    run_op(2'b00, 32'd7, 32'd9, lat);
    chk("t5_latency", 64'(lat), 64'd33);
    chk("t5_result", {bus.hi, bus.lo}, 64'd63);
    finish_op();

    // 6: random operands across all ops against a 64-bit reference
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'd0; tick();
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    m = 64'd0;
    for (int i = 0; i < 1000; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = 32'h80000000;
      if (i % 8 == 1) b = 32'hFFFFFFFF;
      if (i % 8 == 2) a = 32'd0;
      sp = $signed(a) * $signed(b);
      up = {32'b0, a} * {32'b0, b};
      p  = (o == 2'b01) ? up : sp;
      case (o)
        2'b10:   m = m + p;
        2'b11:   m = m - p;
        default: m = p;
      endcase
      run_op(o, a, b, lat);
      chk($sformatf("t6_rand%0d_op%0d", i, o), {bus.hi, bus.lo}, m);
      finish_op();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
